// File: rtl/jmbl_pair_counter_gen.sv
// rtl/jmbl_pair_counter_gen.sv - lockstep x/y counter pair with hold/wrap/bounce end-of-range modes
//
// Purpose:
//   Two W-bit counters x and y that always move by the same delta, so that
//   (x - y) mod 2^W never changes. Counting runs up by a selectable step until
//   x reaches LIMIT. What happens next depends on MODE:
//     0 hold   : park in HOLD with done high until reset
//     1 wrap   : reload the initial values and pulse done for one cycle
//     2 bounce : pulse done, count back down to X_INIT, then count up again
//
// Ports:
//   clk      in   rising-edge clock for all state
//   rst      in   synchronous reset, active-low, overrides everything
//   en       in   advance enable; low freezes x, y and state
//   selector in   step select: 0 -> STEP_A, 1 -> STEP_B
//   x        out  counter x (registered)
//   y        out  counter y (registered)
//   state    out  FSM state: 00 RUN_UP, 01 RUN_DOWN, 10 HOLD
//   done     out  end-of-range indication (registered)

module jmbl_pair_counter_gen #(
  parameter int W      = 11,
  parameter int X_INIT = 2,
  parameter int Y_INIT = 1,
  parameter int STEP_A = 2,
  parameter int STEP_B = 1,
  parameter int LIMIT  = 200,
  parameter int MODE   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         selector,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [1:0]   state,
  output logic         done
);

  typedef enum logic [1:0] {
    RUN_UP   = 2'b00,
    RUN_DOWN = 2'b01,
    HOLD     = 2'b10,
    UNUSED   = 2'b11
  } state_t;

  localparam logic [W-1:0] X0      = W'(X_INIT);
  localparam logic [W-1:0] Y0      = W'(Y_INIT);
  localparam logic [W-1:0] STEP_AW = W'(STEP_A);
  localparam logic [W-1:0] STEP_BW = W'(STEP_B);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  state_t       cur;
  logic [W-1:0] step;
  logic [W-1:0] room;
  logic [W-1:0] down_delta;

  assign state = cur;
  assign step  = selector ? STEP_BW : STEP_AW;

  // Distance left to X_INIT while counting down; the down step is clamped to it
  // so x lands exactly on X_INIT instead of undershooting.
  assign room       = x - X0;
  assign down_delta = (step < room) ? step : room;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x    <= X0;
      y    <= Y0;
      cur  <= RUN_UP;
      done <= 1'b0;
    end else begin
      // Level part of done: high only while parked in HOLD. The one-cycle
      // pulses for wrap and bounce override this below.
      done <= (cur == HOLD);
      case (cur)
        RUN_UP: begin
          if (en) begin
            if (x < LIMIT_W) begin
              x <= x + step;
              y <= y + step;
            end else if (MODE == 1) begin
              x    <= X0;
              y    <= Y0;
              done <= 1'b1;
            end else if (MODE == 2) begin
              cur  <= RUN_DOWN;
              done <= 1'b1;
            end else begin
              cur  <= HOLD;
              done <= 1'b1;
            end
          end
        end
        RUN_DOWN: begin
          if (en) begin
            if (x > X0) begin
              x <= x - down_delta;
              y <= y - down_delta;
            end else begin
              cur <= RUN_UP;
            end
          end
        end
        HOLD: begin
          // Absorbing: only reset leaves this state.
        end
        default: begin
          // Unused encoding recovers to RUN_UP without touching the counters.
          cur  <= RUN_UP;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jmbl_pair_counter_gen.sv
// tb/tb_jmbl_pair_counter_gen.sv - directed self-checking bench for jmbl_pair_counter_gen

module tb_jmbl_pair_counter_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        selector;
  logic [10:0] x0, y0, x1, y1, x2, y2;
  logic [1:0]  s0, s1, s2;
  logic        d0, d1, d2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Default configuration: hold at 200.
  jmbl_pair_counter_gen dut0 (
    .clk(clk), .rst(rst), .en(en), .selector(selector),
    .x(x0), .y(y0), .state(s0), .done(d0)
  );

  // Wrap at 10.
  jmbl_pair_counter_gen #(.LIMIT(10), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .selector(selector),
    .x(x1), .y(y1), .state(s1), .done(d1)
  );

  // Bounce at 10 with STEP_A=3.
  jmbl_pair_counter_gen #(.LIMIT(10), .STEP_A(3), .MODE(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .selector(selector),
    .x(x2), .y(y2), .state(s2), .done(d2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en  = 1'b1;
    selector = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; selector = 1'b0;
    tick(); tick();
    checks++; if (x0 !== 11'd2) begin failures++; $display("FAIL reset_x got=%0d exp=2", x0); end
    checks++; if (y0 !== 11'd1) begin failures++; $display("FAIL reset_y got=%0d exp=1", y0); end
    checks++; if (s0 !== 2'b00) begin failures++; $display("FAIL reset_state got=%0d exp=0", s0); end
    checks++; if (d0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", d0); end
    checks++; if (x1 !== 11'd2 || x2 !== 11'd2) begin failures++; $display("FAIL reset_x_others got=%0d,%0d exp=2", x1, x2); end
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (x0 !== 11'd2 || y0 !== 11'd1) begin failures++; $display("FAIL en0_hold x=%0d y=%0d exp=2,1", x0, y0); end
    end
  endtask

  task automatic test_mode0_hold();
    int ex;
    do_reset();
    ex = 2;
    for (int i = 0; i < 99; i++) begin
      tick();
      ex += 2;
      checks++; if (x0 !== 11'(ex) || (x0 - y0) !== 11'd1) begin failures++; $display("FAIL m0_count i=%0d x=%0d y=%0d exp_x=%0d", i, x0, y0, ex); end
    end
    checks++; if (x0 !== 11'd200 || y0 !== 11'd199 || s0 !== 2'b00 || d0 !== 1'b0) begin
      failures++; $display("FAIL m0_at_limit x=%0d y=%0d st=%0d done=%0d exp=200,199,0,0", x0, y0, s0, d0); end
    tick();
    checks++; if (s0 !== 2'b10 || d0 !== 1'b1) begin failures++; $display("FAIL m0_enter_hold st=%0d done=%0d exp=2,1", s0, d0); end
    for (int i = 0; i < 20; i++) begin
      selector = i[0];
      tick();
      checks++; if (x0 !== 11'd200 || y0 !== 11'd199 || s0 !== 2'b10 || d0 !== 1'b1) begin
        failures++; $display("FAIL m0_hold i=%0d x=%0d y=%0d st=%0d done=%0d exp=200,199,2,1", i, x0, y0, s0, d0); end
    end
    en = 1'b0;
    tick();
    checks++; if (d0 !== 1'b1 || s0 !== 2'b10) begin failures++; $display("FAIL m0_hold_en0 done=%0d st=%0d exp=1,2", d0, s0); end
    en = 1'b1;
  endtask

  task automatic test_step_mix();
    int sel[5] = '{1, 1, 1, 0, 0};
    int ex[5]  = '{3, 4, 5, 7, 9};
    int ey[5]  = '{2, 3, 4, 6, 8};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      selector = sel[i][0];
      tick();
      checks++; if (x0 !== 11'(ex[i]) || y0 !== 11'(ey[i]) || (x0 - y0) !== 11'd1) begin
        failures++; $display("FAIL step_mix i=%0d x=%0d y=%0d exp=%0d,%0d", i, x0, y0, ex[i], ey[i]); end
    end
  endtask

  task automatic test_enable_freeze();
    // Continues from x=9, y=8.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      selector = ~selector;
      tick();
      checks++; if (x0 !== 11'd9 || y0 !== 11'd8 || s0 !== 2'b00 || d0 !== 1'b0) begin
        failures++; $display("FAIL freeze i=%0d x=%0d y=%0d st=%0d done=%0d exp=9,8,0,0", i, x0, y0, s0, d0); end
    end
    en = 1'b1; selector = 1'b1;
    tick();
    checks++; if (x0 !== 11'd10 || y0 !== 11'd9) begin failures++; $display("FAIL unfreeze x=%0d y=%0d exp=10,9", x0, y0); end
  endtask

  task automatic test_mode1_wrap();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 4; k++) begin
        tick();
        checks++; if (x1 !== 11'(2 + 2 * k) || y1 !== 11'(1 + 2 * k) || d1 !== 1'b0) begin
          failures++; $display("FAIL m1_up r=%0d k=%0d x=%0d y=%0d done=%0d exp_x=%0d", r, k, x1, y1, d1, 2 + 2 * k); end
      end
      tick();
      checks++; if (x1 !== 11'd2 || y1 !== 11'd1 || d1 !== 1'b1 || s1 !== 2'b00) begin
        failures++; $display("FAIL m1_wrap r=%0d x=%0d y=%0d done=%0d st=%0d exp=2,1,1,0", r, x1, y1, d1, s1); end
    end
    tick();
    checks++; if (x1 !== 11'd4 || d1 !== 1'b0) begin failures++; $display("FAIL m1_after_wrap x=%0d done=%0d exp=4,0", x1, d1); end
  endtask

  task automatic test_mode2_bounce();
    int ux[3] = '{5, 8, 11};
    int dx[3] = '{8, 5, 2};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (x2 !== 11'(ux[i]) || (x2 - y2) !== 11'd1 || s2 !== 2'b00 || d2 !== 1'b0) begin
        failures++; $display("FAIL m2_up i=%0d x=%0d y=%0d st=%0d done=%0d exp_x=%0d", i, x2, y2, s2, d2, ux[i]); end
    end
    tick();
    checks++; if (x2 !== 11'd11 || y2 !== 11'd10 || s2 !== 2'b01 || d2 !== 1'b1) begin
      failures++; $display("FAIL m2_turn x=%0d y=%0d st=%0d done=%0d exp=11,10,1,1", x2, y2, s2, d2); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (x2 !== 11'(dx[i]) || (x2 - y2) !== 11'd1 || s2 !== 2'b01 || d2 !== 1'b0) begin
        failures++; $display("FAIL m2_down i=%0d x=%0d y=%0d st=%0d done=%0d exp_x=%0d", i, x2, y2, s2, d2, dx[i]); end
    end
    tick();
    checks++; if (x2 !== 11'd2 || y2 !== 11'd1 || s2 !== 2'b00 || d2 !== 1'b0) begin
      failures++; $display("FAIL m2_return x=%0d y=%0d st=%0d done=%0d exp=2,1,0,0", x2, y2, s2, d2); end
    tick();
    checks++; if (x2 !== 11'd5) begin failures++; $display("FAIL m2_reup x=%0d exp=5", x2); end
  endtask

  task automatic test_mode2_clamp();
    // Up 5,8 (step 3), 9,10 (step 1), turn at 10, down 7,4 then clamped to 2.
    int sel[9] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    int ex[9]  = '{5, 8, 9, 10, 10, 7, 4, 2, 2};
    int es[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int ed[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      selector = sel[i][0];
      tick();
      checks++; if (x2 !== 11'(ex[i]) || (x2 - y2) !== 11'd1 || s2 !== 2'(es[i]) || d2 !== ed[i][0]) begin
        failures++; $display("FAIL m2_clamp i=%0d x=%0d y=%0d st=%0d done=%0d exp=%0d,-,%0d,%0d", i, x2, y2, s2, d2, ex[i], es[i], ed[i]); end
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    for (int i = 0; i < 49; i++) tick();
    checks++; if (x0 !== 11'd100 || y0 !== 11'd99) begin failures++; $display("FAIL mid_pre x=%0d y=%0d exp=100,99", x0, y0); end
    rst = 1'b0;
    tick();
    checks++; if (x0 !== 11'd2 || y0 !== 11'd1 || s0 !== 2'b00 || d0 !== 1'b0) begin
      failures++; $display("FAIL mid_reset x=%0d y=%0d st=%0d done=%0d exp=2,1,0,0", x0, y0, s0, d0); end
    rst = 1'b1;
    tick(); tick();
    checks++; if (x0 !== 11'd6 || y0 !== 11'd5) begin failures++; $display("FAIL mid_resume x=%0d y=%0d exp=6,5", x0, y0); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; selector = 1'b0;
    test_reset();
    test_mode0_hold();
    test_step_mix();
    test_enable_freeze();
    test_mode1_wrap();
    test_mode2_bounce();
    test_mode2_clamp();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jmbl_pair_counter_gen.md
Name: jmbl_pair_counter_gen

Overview:
Parametrised lockstep counter pair (x, y) for the arithmetic invariant-mining benchmark set. It generalises the fixed 11-bit, step-2, limit-200 counter pair with:
- configurable width, initial values, limit and two selectable steps;
- an enable input;
- three end-of-range modes (hold, wrap, bounce) driven by a small state machine.
By construction x - y stays constant (mod 2^W). This gives the mining flow a richer but still provable target.

Parameters:
W, 11, width of x and y
X_INIT, 2, reset/restart value of x
Y_INIT, 1, reset/restart value of y
STEP_A, 2, increment when selector=0
STEP_B, 1, increment when selector=1
LIMIT, 200, x threshold (unsigned) ending the up phase
MODE, 0, end-of-range behaviour: 0 hold, 1 wrap, 2 bounce

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on next clk edge)
en  input  1  advance enable; en=0 freezes x, y, state
selector  input  1  step select: 0 -> STEP_A, 1 -> STEP_B; sampled every cycle
x  output  W  counter x (registered)
y  output  W  counter y (registered)
state  output  2  FSM state: 00 RUN_UP, 01 RUN_DOWN, 10 HOLD
done  output  1  end-of-range indication (registered)

Behaviour:
- Reset (rst=0, overrides everything, any state): x=X_INIT, y=Y_INIT, state=RUN_UP, done=0.
- step = selector ? STEP_B : STEP_A. Arithmetic is unsigned and modulo 2^W.
- Legal configuration: LIMIT + max(STEP_A, STEP_B) < 2^W and X_INIT < LIMIT. Overflow is then impossible.
- Invariant: every update adds or subtracts the same delta to both x and y, and a wrap restores both to their initial values. Hence (x - y) mod 2^W == (X_INIT - Y_INIT) mod 2^W on every cycle.
- en=0: x, y, state hold. done follows the per-state rule below, with no pulse generated.
- RUN_UP, en=1:
  - x < LIMIT: x += step, y += step. Overshoot past LIMIT is permitted.
  - x >= LIMIT, MODE0: go to HOLD, x/y unchanged.
  - x >= LIMIT, MODE1: x=X_INIT, y=Y_INIT, stay RUN_UP, done=1 for that one cycle.
  - x >= LIMIT, MODE2: go to RUN_DOWN, x/y unchanged, done=1 for one cycle.
- RUN_DOWN (MODE2 only), en=1:
  - x > X_INIT: delta = min(step, x - X_INIT); x -= delta, y -= delta. Never undershoots X_INIT.
  - x == X_INIT: go to RUN_UP, x/y unchanged.
- HOLD (MODE0 only): absorbing; x, y frozen; done=1 continuously. Exit only via reset.
- done in RUN_UP/RUN_DOWN: 0 except for the single-cycle pulses above.
- selector change mid-run takes effect on the next update; no state change is caused by it.
- Reset asserted during any state: next cycle returns to the reset values, regardless of en.
- Unused state encoding 11: next cycle forced to RUN_UP, x/y unchanged.

Test Plan:
- Reset: rst=0 for 2 cycles with en=1 -> x=2, y=1, state=00, done=0; en=0 after rst release -> values held.
- MODE0 defaults, selector=0, en=1:
  - after 99 enabled cycles x=200, y=199;
  - next cycle state=10, done=1;
  - x=200, y=199 held for 20 further cycles.
- Step mixing: selector=1 for 3 cycles, then 0 for 2 -> x: 3,4,5,7,9, y: 2,3,4,6,8; assert x-y==1 every cycle.
- MODE1, LIMIT=10:
  - x: 2,4,6,8,10, then x=2, y=1 with done=1 for exactly one cycle;
  - sequence repeats.
- MODE2, LIMIT=10, STEP_A=3:
  - up 2,5,8,11;
  - turn cycle: x=11, state=01, done pulse;
  - down 8,5,2;
  - next: state=00, x=2;
  - y tracks x-1 throughout.
- Mid-run reset: MODE0 at x=100, drive rst=0 one cycle -> x=2, y=1, state=00; counting resumes normally.
